panel_load_sequencer: RTL and testbench

Synthesizable front-panel sequencer for the PDP-8 top level. On a start pulse it drives the `Top` switch and button inputs to zero the PC, deposit a full memory image word by word from an image ROM, load the start PC, and set the run switch. It then watches the run indicator and pulses `done` when the program halts. It replaces hand-timed button stimulus so that emulator runs and board bring-up use one cycle-exact load path.

---
 rtl/panel_load_sequencer_pkg.sv | 34 +++
 rtl/panel_load_sequencer_hold_timer.sv | 40 ++++
 rtl/panel_load_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_panel_load_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/panel_load_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// panel_load_sequencer_pkg
//
// Shared definitions for the PDP-8 front-panel load sequencer:
//   - panel_seq_state_t : sequencer state encoding
//   - PANEL_RUN_BIT     : index of the run switch inside the 13-bit switch bus
//   - DEFAULT_START_PC  : PC loaded before the run switch is set (octal 0200)
// -----------------------------------------------------------------------------
package panel_load_sequencer_pkg;

    localparam int          PANEL_RUN_BIT    = 12;
    localparam int          PANEL_DATA_W     = 12;
    localparam int          WORD_COUNT_W     = 13;
    localparam logic [11:0] DEFAULT_START_PC = 12'o0200;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ZPC_SET   = 4'd1,
        ST_ZPC_HI    = 4'd2,
        ST_ZPC_LO    = 4'd3,
        ST_FETCH     = 4'd4,
        ST_DSET      = 4'd5,
        ST_DEP_HI    = 4'd6,
        ST_DEP_LO    = 4'd7,
        ST_SPC_SET   = 4'd8,
        ST_SPC_HI    = 4'd9,
        ST_SPC_LO    = 4'd10,
        ST_RUN       = 4'd11,
        ST_WAIT_RUN  = 4'd12,
        ST_WAIT_HALT = 4'd13,
        ST_DONE      = 4'd14
    } panel_seq_state_t;

endpackage

// File: rtl/panel_load_sequencer_hold_timer.sv
// -----------------------------------------------------------------------------
// hold_timer
//
// Loadable down-counter that times how long each switch/button level is held.
// A load makes the current state last exactly HOLD_CYCLES clocks: the counter
// restarts at HOLD_CYCLES-1 and `expired` is high in the last held clock.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high
//   load     in   restart the hold interval (asserted on every state entry)
//   expired  out  high while the count is zero (hold interval complete)
// -----------------------------------------------------------------------------
module hold_timer #(
    parameter int HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expired
);

    localparam int             CW     = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0]  RELOAD = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/panel_load_sequencer.sv
// -----------------------------------------------------------------------------
// panel_load_sequencer
//
// Front-panel sequencer for the PDP-8 top level. On `start` it zeroes the PC
// through the load-address button, deposits MEM_WORDS words read from an
// external image ROM (the CPU auto-increments its PC on every deposit), loads
// START_PC, sets the run switch and then waits for the CPU to run and halt,
// pulsing `done` on the halt.
//
// Parameters:
//   HOLD_CYCLES  clocks each switch/button level is held (>= 1)
//   MEM_WORDS    words deposited from address 0 (1..4096)
//   START_PC     PC loaded before the run switch is set
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high; returns to IDLE, all outputs 0
//   start     in   one-cycle load-and-run request (ignored unless IDLE)
//   img_addr  out  image ROM read address
//   img_data  in   image ROM data, valid one clock after img_addr
//   sw        out  switches: [11:0] data, [12] run
//   load_pc   out  load-address button (btnl)
//   deposit   out  deposit button (btnd)
//   run_led   in   CPU run indicator
//   busy      out  high from accepted start until done
//   done      out  one-cycle pulse when the program halts
//
// All outputs are registered and take their new value on the clock edge that
// enters the state they belong to.
// -----------------------------------------------------------------------------
module panel_load_sequencer
    import panel_load_sequencer_pkg::*;
#(
    parameter int          HOLD_CYCLES = 10,
    parameter int          MEM_WORDS   = 4096,
    parameter logic [11:0] START_PC    = DEFAULT_START_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [11:0] img_addr,
    input  logic [11:0] img_data,
    output logic [12:0] sw,
    output logic        load_pc,
    output logic        deposit,
    input  logic        run_led,
    output logic        busy,
    output logic        done
);

    // 13-bit compare so MEM_WORDS = 4096 ends at 4095 instead of wrapping.
    localparam logic [WORD_COUNT_W-1:0] LAST_WC = WORD_COUNT_W'(MEM_WORDS - 1);

    panel_seq_state_t state, state_next;

    logic [WORD_COUNT_W-1:0] wc, wc_next, wc_plus1;
    logic [11:0]             sw_data_q, sw_data_next;
    logic                    sw_run_q, sw_run_next;
    logic                    load_pc_q, load_pc_next;
    logic                    deposit_q, deposit_next;
    logic                    busy_q, busy_next;
    logic                    done_q, done_next;
    logic [11:0]             img_addr_q, img_addr_next;
    logic                    run_led_q;
    logic                    timer_load;
    logic                    hold_done;

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .expired (hold_done)
    );

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            wc         <= '0;
            sw_data_q  <= '0;
            sw_run_q   <= 1'b0;
            load_pc_q  <= 1'b0;
            deposit_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            img_addr_q <= '0;
            run_led_q  <= 1'b0;
        end else begin
            state      <= state_next;
            wc         <= wc_next;
            sw_data_q  <= sw_data_next;
            sw_run_q   <= sw_run_next;
            load_pc_q  <= load_pc_next;
            deposit_q  <= deposit_next;
            busy_q     <= busy_next;
            done_q     <= done_next;
            img_addr_q <= img_addr_next;
            run_led_q  <= run_led;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;

        case (state)
            ST_IDLE:      if (start)     state_next = ST_ZPC_SET;
            ST_ZPC_SET:   if (hold_done) state_next = ST_ZPC_HI;
            ST_ZPC_HI:    if (hold_done) state_next = ST_ZPC_LO;
            ST_ZPC_LO:    if (hold_done) state_next = ST_FETCH;
            ST_FETCH:                    state_next = ST_DSET;
            ST_DSET:      if (hold_done) state_next = ST_DEP_HI;
            ST_DEP_HI:    if (hold_done) state_next = ST_DEP_LO;
            ST_DEP_LO: begin
                if (hold_done) begin
                    state_next = (wc == LAST_WC) ? ST_SPC_SET : ST_FETCH;
                end
            end
            ST_SPC_SET:   if (hold_done) state_next = ST_SPC_HI;
            ST_SPC_HI:    if (hold_done) state_next = ST_SPC_LO;
            ST_SPC_LO:    if (hold_done) state_next = ST_RUN;
            ST_RUN:                      state_next = ST_WAIT_RUN;
            // A low run_led here is never a halt: the CPU must be seen running first.
            ST_WAIT_RUN:  if (run_led)   state_next = ST_WAIT_HALT;
            ST_WAIT_HALT: if (run_led_q && !run_led) state_next = ST_DONE;
            ST_DONE:                     state_next = ST_IDLE;
            default:                     state_next = ST_IDLE;
        endcase

        // Every transition goes to a different state, so a change of state is
        // exactly a state entry and restarts the hold interval.
        timer_load = (state_next != state);
    end

    // -------------------------------------------------------------------------
    // Registered-output next values, updated only on state entry
    // -------------------------------------------------------------------------
    always_comb begin
        wc_next       = wc;
        wc_plus1      = wc + WORD_COUNT_W'(1);
        sw_data_next  = sw_data_q;
        sw_run_next   = sw_run_q;
        load_pc_next  = load_pc_q;
        deposit_next  = deposit_q;
        busy_next     = busy_q;
        done_next     = done_q;
        img_addr_next = img_addr_q;

        if (state_next != state) begin
            case (state_next)
                ST_IDLE: begin
                    wc_next       = '0;
                    sw_data_next  = '0;
                    sw_run_next   = 1'b0;
                    load_pc_next  = 1'b0;
                    deposit_next  = 1'b0;
                    busy_next     = 1'b0;
                    done_next     = 1'b0;
                    img_addr_next = '0;
                end
                ST_ZPC_SET: begin
                    busy_next     = 1'b1;
                    sw_data_next  = '0;
                    wc_next       = '0;
                    img_addr_next = '0;
                end
                ST_ZPC_HI, ST_SPC_HI: load_pc_next = 1'b1;
                ST_ZPC_LO, ST_SPC_LO: load_pc_next = 1'b0;
                ST_FETCH: begin
                    if (state == ST_DEP_LO) begin
                        wc_next = wc_plus1;
                    end
                    img_addr_next = wc_next[11:0];
                end
                ST_DSET:    sw_data_next = img_data;
                ST_DEP_HI:  deposit_next = 1'b1;
                ST_DEP_LO: begin
                    deposit_next = 1'b0;
                    // Present the next address early so a registered ROM has
                    // its data ready by the time DSET captures it. The last
                    // word keeps its address, so img_addr never wraps to 0.
                    if (wc != LAST_WC) begin
                        img_addr_next = wc_plus1[11:0];
                    end
                end
                ST_SPC_SET: sw_data_next = START_PC;
                ST_RUN:     sw_run_next  = 1'b1;
                ST_DONE: begin
                    done_next = 1'b1;
                    busy_next = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign sw[PANEL_RUN_BIT]     = sw_run_q;
    assign sw[PANEL_DATA_W-1:0]  = sw_data_q;
    assign load_pc               = load_pc_q;
    assign deposit               = deposit_q;
    assign busy                  = busy_q;
    assign done                  = done_q;
    assign img_addr              = img_addr_q;

endmodule

// File: tb/tb_panel_load_sequencer.sv
// -----------------------------------------------------------------------------
// tb_panel_load_sequencer
//
// Three sequencer instances share one clock:
//   A: HOLD=2,  MEM_WORDS=4    image {7001,7001,7402,0}, cycle-exact event table
//   B: HOLD=1,  MEM_WORDS=4096 full memory image, address/wrap/spacing
//   C: HOLD=10, MEM_WORDS=3    spacing between switch changes and button edges
// Outputs are sampled 1 ns after the falling clock edge.
// -----------------------------------------------------------------------------
module tb_panel_load_sequencer;
    import panel_load_sequencer_pkg::*;

    typedef enum int { EV_LOAD = 0, EV_DEP = 1, EV_RUN = 2 } ev_kind_e;

    // One expected front-panel event: kind, clock offset from busy rising,
    // and the switch data presented at that moment.
    typedef struct {
        ev_kind_e    kind;
        int          cyc;
        logic [11:0] sw;
    } ev_t;

    typedef struct {
        logic [11:0] sw;
        logic        lp;
        logic        dep;
        logic        busy;
        int          gap;
        int          errs;
        int          rises;
    } mon_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // ---------------- DUT A ----------------
    logic        reset_a, start_a, run_led_a;
    logic [11:0] img_addr_a, img_data_a;
    logic [12:0] sw_a;
    logic        load_pc_a, deposit_a, busy_a, done_a;
    logic [11:0] rom_a [4];

    panel_load_sequencer #(.HOLD_CYCLES(2), .MEM_WORDS(4), .START_PC(12'o0200)) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .img_addr(img_addr_a),
        .img_data(img_data_a), .sw(sw_a), .load_pc(load_pc_a), .deposit(deposit_a),
        .run_led(run_led_a), .busy(busy_a), .done(done_a)
    );
    always_ff @(posedge clk) img_data_a <= rom_a[img_addr_a[1:0]];

    // ---------------- DUT B ----------------
    logic        reset_b, start_b, run_led_b;
    logic [11:0] img_addr_b, img_data_b;
    logic [12:0] sw_b;
    logic        load_pc_b, deposit_b, busy_b, done_b;
    logic [11:0] rom_b [4096];

    panel_load_sequencer #(.HOLD_CYCLES(1), .MEM_WORDS(4096), .START_PC(12'o0200)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .img_addr(img_addr_b),
        .img_data(img_data_b), .sw(sw_b), .load_pc(load_pc_b), .deposit(deposit_b),
        .run_led(run_led_b), .busy(busy_b), .done(done_b)
    );
    always_ff @(posedge clk) img_data_b <= rom_b[img_addr_b];

    // ---------------- DUT C ----------------
    logic        reset_c, start_c, run_led_c;
    logic [11:0] img_addr_c, img_data_c;
    logic [12:0] sw_c;
    logic        load_pc_c, deposit_c, busy_c, done_c;
    logic [11:0] rom_c [4];

    panel_load_sequencer #(.HOLD_CYCLES(10), .MEM_WORDS(3), .START_PC(12'o0200)) dut_c (
        .clk(clk), .reset(reset_c), .start(start_c), .img_addr(img_addr_c),
        .img_data(img_data_c), .sw(sw_c), .load_pc(load_pc_c), .deposit(deposit_c),
        .run_led(run_led_c), .busy(busy_c), .done(done_c)
    );
    always_ff @(posedge clk) img_data_c <= rom_c[img_addr_c[1:0]];

    function automatic logic [11:0] rom_b_word(input int i);
        return 12'(i) ^ 12'o5252;
    endfunction

    // Spacing rules: a button rises exactly HOLD clocks after the previous
    // panel event, stays high exactly HOLD clocks, and switch data never
    // changes sooner than HOLD clocks after the previous event.
    function automatic mon_t spacing_step(input mon_t m, input logic [11:0] sw,
                                          input logic lp, input logic dep,
                                          input logic busy, input int hold);
        mon_t r;
        logic rise, fall, sw_ch;
        r     = m;
        rise  = (lp && !m.lp) || (dep && !m.dep);
        fall  = (!lp && m.lp) || (!dep && m.dep);
        sw_ch = busy && m.busy && (sw != m.sw);
        r.gap = m.gap + 1;
        if (rise) begin
            r.rises = r.rises + 1;
            if (r.gap != hold) r.errs = r.errs + 1;
        end
        if (fall && r.gap != hold) r.errs = r.errs + 1;
        if (sw_ch && r.gap < hold) r.errs = r.errs + 1;
        if (rise || fall || sw_ch || (busy && !m.busy)) r.gap = 0;
        r.sw   = sw;
        r.lp   = lp;
        r.dep  = dep;
        r.busy = busy;
        return r;
    endfunction

    // ---------------- monitors (falling edge) ----------------
    int   cyc_a = 0, dep_cnt_a = 0, done_cnt_a = 0;
    ev_t  ev_q[$];
    logic prev_lp_a = 1'b0, prev_dep_a = 1'b0, prev_run_a = 1'b0, prev_busy_a = 1'b0;

    always @(negedge clk) begin
        if (busy_a && !prev_busy_a) begin
            cyc_a     = 0;
            dep_cnt_a = 0;
        end else begin
            cyc_a++;
        end
        if (load_pc_a && !prev_lp_a) ev_q.push_back('{kind: EV_LOAD, cyc: cyc_a, sw: sw_a[11:0]});
        if (deposit_a && !prev_dep_a) begin
            ev_q.push_back('{kind: EV_DEP, cyc: cyc_a, sw: sw_a[11:0]});
            dep_cnt_a++;
        end
        if (sw_a[12] && !prev_run_a) ev_q.push_back('{kind: EV_RUN, cyc: cyc_a, sw: sw_a[11:0]});
        if (done_a) done_cnt_a++;
        prev_lp_a   = load_pc_a;
        prev_dep_a  = deposit_a;
        prev_run_a  = sw_a[12];
        prev_busy_a = busy_a;
    end

    int          cyc_b = 0, dep_cnt_b = 0, data_err_b = 0, addr_err_b = 0, run_cyc_b = -1;
    logic [11:0] last_addr_b = '0;
    logic        prev_dep_b = 1'b0, prev_run_b = 1'b0, prev_busy_b = 1'b0;
    mon_t        mon_b = '{default: '0};

    always @(negedge clk) begin
        if (busy_b && !prev_busy_b) cyc_b = 0;
        else cyc_b++;
        if (deposit_b && !prev_dep_b) begin
            if (sw_b[11:0] !== rom_b_word(dep_cnt_b)) data_err_b++;
            if (img_addr_b !== 12'(dep_cnt_b)) addr_err_b++;
            last_addr_b = img_addr_b;
            dep_cnt_b++;
        end
        if (sw_b[12] && !prev_run_b) run_cyc_b = cyc_b;
        mon_b = spacing_step(mon_b, sw_b[11:0], load_pc_b, deposit_b, busy_b, 1);
        prev_dep_b  = deposit_b;
        prev_run_b  = sw_b[12];
        prev_busy_b = busy_b;
    end

    int   cyc_c = 0, dep_cnt_c = 0, data_err_c = 0, run_cyc_c = -1;
    logic prev_dep_c = 1'b0, prev_run_c = 1'b0, prev_busy_c = 1'b0;
    mon_t mon_c = '{default: '0};

    always @(negedge clk) begin
        if (busy_c && !prev_busy_c) cyc_c = 0;
        else cyc_c++;
        if (deposit_c && !prev_dep_c) begin
            if (dep_cnt_c > 2 || sw_c[11:0] !== rom_c[dep_cnt_c[1:0]]) data_err_c++;
            dep_cnt_c++;
        end
        if (sw_c[12] && !prev_run_c) run_cyc_c = cyc_c;
        mon_c = spacing_step(mon_c, sw_c[11:0], load_pc_c, deposit_c, busy_c, 10);
        prev_dep_c  = deposit_c;
        prev_run_c  = sw_c[12];
        prev_busy_c = busy_c;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    ev_t exp_a [7];

    // Pulse start, optionally keep pulsing it while busy, wait for the run
    // switch and compare the recorded panel events against the table.
    task automatic run_a(input bit spam, input string tag);
        ev_q.delete();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 200 && !sw_a[12]; i++) begin
            if (spam) start_a = (i % 3 == 0);
            tick();
        end
        start_a = 1'b0;
        check({tag, "_run_reached"}, 32'(sw_a[12]), 32'd1);
        check({tag, "_event_count"}, 32'(ev_q.size()), 32'd7);
        check({tag, "_deposits"}, 32'(dep_cnt_a), 32'd4);
        for (int i = 0; i < 7; i++) begin
            if (i < ev_q.size()) begin
                check($sformatf("%s_ev%0d_kind", tag, i), 32'(ev_q[i].kind), 32'(exp_a[i].kind));
                check($sformatf("%s_ev%0d_cyc", tag, i), 32'(ev_q[i].cyc), 32'(exp_a[i].cyc));
                check($sformatf("%s_ev%0d_sw", tag, i), 32'(ev_q[i].sw), 32'(exp_a[i].sw));
            end else begin
                n_vec++;
                n_miss++;
                $display("FAIL %s_ev%0d: event missing, want kind %0d at cycle %0d",
                         tag, i, exp_a[i].kind, exp_a[i].cyc);
            end
        end
    endtask

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        // Expected panel events for A (H=2): ZPC load at 2, words every 7
        // clocks from 9, start-PC load at 6+4*7+2 = 36, run at 6*2+4*7 = 40.
        exp_a[0] = '{kind: EV_LOAD, cyc: 2,  sw: 12'o0000};
        exp_a[1] = '{kind: EV_DEP,  cyc: 9,  sw: 12'o7001};
        exp_a[2] = '{kind: EV_DEP,  cyc: 16, sw: 12'o7001};
        exp_a[3] = '{kind: EV_DEP,  cyc: 23, sw: 12'o7402};
        exp_a[4] = '{kind: EV_DEP,  cyc: 30, sw: 12'o0000};
        exp_a[5] = '{kind: EV_LOAD, cyc: 36, sw: 12'o0200};
        exp_a[6] = '{kind: EV_RUN,  cyc: 40, sw: 12'o0200};

        rom_a[0] = 12'o7001; rom_a[1] = 12'o7001; rom_a[2] = 12'o7402; rom_a[3] = 12'o0000;
        for (int i = 0; i < 4096; i++) rom_b[i] = rom_b_word(i);
        rom_c[0] = 12'o1234; rom_c[1] = 12'o4321; rom_c[2] = 12'o7070; rom_c[3] = 12'o0000;

        reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        run_led_a = 1'b0; run_led_b = 1'b0; run_led_c = 1'b0;
        repeat (3) tick();
        check("por_outputs", {img_addr_a, sw_a, load_pc_a, deposit_a, busy_a, done_a}, 32'd0);
        reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0;
        tick();

        // Load with run_led already high, dropping in the RUN-entry clock.
        run_led_a = 1'b1;
        run_a(1'b0, "load1");
        run_led_a = 1'b0;
        repeat (4) tick();
        check("early_fall_no_done", 32'(done_cnt_a), 32'd0);
        check("early_fall_busy", 32'(busy_a), 32'd1);

        // Halt: run_led 0 -> 1 -> 0.
        run_led_a = 1'b1;
        repeat (3) tick();
        check("running_busy", {busy_a, done_a}, {30'd0, 2'b10});
        run_led_a = 1'b0;
        tick();
        check("halt_done_pulse", 32'(done_a), 32'd1);
        check("halt_busy_low", 32'(busy_a), 32'd0);
        tick();
        check("after_done_low", 32'(done_a), 32'd0);
        check("after_done_sw", 32'(sw_a), 32'd0);
        check("after_done_addr", 32'(img_addr_a), 32'd0);
        repeat (3) tick();
        check("single_done", 32'(done_cnt_a), 32'd1);

        // Reset during the third DEP_HI.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 200 && dep_cnt_a != 3; i++) tick();
        check("third_deposit_seen", 32'(deposit_a && dep_cnt_a == 3), 32'd1);
        reset_a = 1'b1;
        tick();
        check("reset_outputs", {img_addr_a, sw_a, load_pc_a, deposit_a, busy_a, done_a}, 32'd0);
        check("reset_state", 32'(dut_a.state), 32'(ST_IDLE));
        reset_a = 1'b0;
        repeat (5) tick();
        check("no_resume", {sw_a, load_pc_a, deposit_a, busy_a}, 32'd0);

        // Restart from word 0 with start hammered while busy.
        run_a(1'b1, "reload");
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;

        // Full 4096-word image (H=1) and H=10 spacing run, together.
        start_b = 1'b1; start_c = 1'b1;
        tick();
        start_b = 1'b0; start_c = 1'b0;
        for (int i = 0; i < 17000 && !(sw_b[12] && sw_c[12]); i++) tick();
        check("b_run_reached", 32'(sw_b[12]), 32'd1);
        check("b_deposits", 32'(dep_cnt_b), 32'd4096);
        check("b_last_addr", 32'(last_addr_b), 32'o7777);
        check("b_addr_hold", 32'(img_addr_b), 32'o7777);
        check("b_addr_errors", 32'(addr_err_b), 32'd0);
        check("b_data_errors", 32'(data_err_b), 32'd0);
        check("b_run_cycle", 32'(run_cyc_b), 32'd16390);
        check("b_spacing_errors", 32'(mon_b.errs), 32'd0);
        check("b_button_rises", 32'(mon_b.rises), 32'd4098);
        check("c_run_reached", 32'(sw_c[12]), 32'd1);
        check("c_deposits", 32'(dep_cnt_c), 32'd3);
        check("c_data_errors", 32'(data_err_c), 32'd0);
        check("c_run_cycle", 32'(run_cyc_c), 32'd153);
        check("c_spacing_errors", 32'(mon_c.errs), 32'd0);
        check("c_button_rises", 32'(mon_c.rises), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
